// File: rtl/sys_arr_feeder_if.sv
// Operand feeder bundle: control handshake, operand RAM ports,
// skewed operand streams and per-PE controls.
interface sys_arr_feeder_if #(
    parameter int N      = 2,
    parameter int ADDR_W = 8
);
    logic                        start;
    logic [ADDR_W-1:0]           k_len;
    logic                        busy;
    logic                        done;
    logic                        ram_own;
    logic [N-1:0][ADDR_W-1:0]    ram_a_addr;
    logic [N-1:0]                ram_a_rden;
    logic [N-1:0][31:0]          ram_a_q;
    logic [N-1:0][ADDR_W-1:0]    ram_w_addr;
    logic [N-1:0]                ram_w_rden;
    logic [N-1:0][31:0]          ram_w_q;
    logic [N-1:0][31:0]          a_in;
    logic [N-1:0][31:0]          w_in;
    logic [N-1:0][N-1:0]         en_mult;
    logic [N-1:0][N-1:0]         clr_mult;
    logic [N-1:0][N-1:0]         en_accum;
    logic [N-1:0][N-1:0]         clr_accum;

    modport master (
        input  start, k_len, ram_a_q, ram_w_q,
        output busy, done, ram_own,
        output ram_a_addr, ram_a_rden, ram_w_addr, ram_w_rden,
        output a_in, w_in,
        output en_mult, clr_mult, en_accum, clr_accum
    );

    modport slave (
        output start, k_len, ram_a_q, ram_w_q,
        input  busy, done, ram_own,
        input  ram_a_addr, ram_a_rden, ram_w_addr, ram_w_rden,
        input  a_in, w_in,
        input  en_mult, clr_mult, en_accum, clr_accum
    );
endinterface

// File: rtl/sys_arr_feeder.sv
// Operand sequencer for the systolic array: reads A rows / W columns
// with a diagonal skew and generates per-PE multiply/accumulate controls.
module sys_arr_feeder #(
    parameter int N        = 2,
    parameter int ADDR_W   = 8,
    parameter int MULT_LAT = 1,
    parameter int ACC_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    sys_arr_feeder_if.master bus
);
    localparam int CW   = ADDR_W + 2;
    localparam int TAIL = 2 * (N - 1) + MULT_LAT + ACC_LAT;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       t_q, t_d;
    logic [ADDR_W-1:0]   k_q, k_d;
    logic [N-1:0]        rd_q, rd_d;
    logic [CW-1:0]       k_ext;
    logic [CW-1:0]       t_last;
    logic                run;
    logic                clear;
    logic [N-1:0][N-1:0] em_c;
    logic [N-1:0][N-1:0] ea_raw;

    assign k_ext  = CW'(k_q);
    assign t_last = k_ext + CW'(TAIL);
    assign run    = (state_q == S_RUN);
    assign clear  = (state_q == S_CLEAR);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            t_q     <= '0;
            k_q     <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            k_q     <= k_d;
            rd_q    <= rd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        k_d     = k_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    k_d     = bus.k_len;
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                t_d     = '0;
                state_d = (k_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                t_d = t_q + 1'b1;
                if (t_q == t_last) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // A rows and W columns share one skew schedule, so one read mask serves both.
    always_comb begin
        rd_d           = '0;
        em_c           = '0;
        bus.ram_a_addr = '0;
        bus.ram_w_addr = '0;
        bus.a_in       = '0;
        bus.w_in       = '0;
        for (int i = 0; i < N; i++) begin
            if (run && t_q >= CW'(i) && (t_q - CW'(i)) < k_ext) begin
                rd_d[i]           = 1'b1;
                bus.ram_a_addr[i] = ADDR_W'(t_q - CW'(i));
                bus.ram_w_addr[i] = ADDR_W'(t_q - CW'(i));
            end
            bus.a_in[i] = rd_q[i] ? bus.ram_a_q[i] : 32'h0;
            bus.w_in[i] = rd_q[i] ? bus.ram_w_q[i] : 32'h0;
            for (int j = 0; j < N; j++) begin
                if (run && t_q > CW'(i + j) &&
                    (t_q - CW'(i + j + 1)) < k_ext)
                    em_c[i][j] = 1'b1;
            end
        end
        bus.ram_a_rden = rd_d;
        bus.ram_w_rden = rd_d;
        bus.busy       = clear || run;
        bus.ram_own    = clear || run;
        bus.done       = (state_q == S_DONE);
        bus.clr_mult   = clear ? '1 : '0;
        bus.clr_accum  = clear ? '1 : '0;
        bus.en_mult    = em_c;
        bus.en_accum   = run ? ea_raw : '0;
    end

    if (MULT_LAT == 0) begin : g_nolat
        assign ea_raw = em_c;
    end else begin : g_lat
        logic [MULT_LAT-1:0][N-1:0][N-1:0] pipe_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                pipe_q <= '0;
            end else begin
                pipe_q[0] <= em_c;
                for (int s = 1; s < MULT_LAT; s++)
                    pipe_q[s] <= pipe_q[s-1];
            end
        end
        assign ea_raw = pipe_q[MULT_LAT-1];
    end
endmodule

// File: tb/tb_sys_arr_feeder.sv
// Scoreboard bench for sys_arr_feeder with behavioural RAMs
// and a small floating-point PE-array model downstream.
module tb_sys_arr_feeder;
    localparam int N  = 2;
    localparam int AW = 8;

    typedef struct packed {
        logic                busy;
        logic                done;
        logic                own;
        logic [1:0]          ar;
        logic [1:0]          wr;
        logic [1:0][7:0]     aa;
        logic [1:0][7:0]     wa;
        logic [1:0][1:0]     em;
        logic [1:0][1:0]     ea;
        logic [1:0][1:0]     cm;
        logic [1:0][1:0]     ca;
    } ctl_t;

    typedef struct packed {
        ctl_t                ctl;
        logic [1:0][31:0]    ai;
        logic [1:0][31:0]    wi;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sys_arr_feeder_if #(.N(N), .ADDR_W(AW)) bif ();

    sys_arr_feeder #(
        .N(N), .ADDR_W(AW), .MULT_LAT(1), .ACC_LAT(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    int n_chk = 0;
    int n_pass = 0;

    logic [31:0] amem [N][256];
    logic [31:0] wmem [N][256];
    real         a_r  [N][4];
    real         w_r  [N][4];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (bif.ram_a_rden[i]) bif.ram_a_q[i] <= amem[i][bif.ram_a_addr[i]];
            if (bif.ram_w_rden[i]) bif.ram_w_q[i] <= wmem[i][bif.ram_w_addr[i]];
        end
    end

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'h0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    // Downstream array: a moves right, w moves down, one cycle per PE.
    logic [31:0] ad [N][N];
    logic [31:0] wd [N][N];
    real         prod [N][N];
    real         acc  [N][N];

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            ad[i][1] = ad[i][0];
            ad[i][0] = bif.a_in[i];
            wd[i][1] = wd[i][0];
            wd[i][0] = bif.w_in[i];
        end
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                if (bif.clr_accum[i][j]) acc[i][j] = 0.0;
                if (bif.en_accum[i][j]) acc[i][j] = acc[i][j] + prod[i][j];
                if (bif.en_mult[i][j])
                    prod[i][j] = f2r(ad[i][j]) * f2r(wd[j][i]);
            end
    end

    int          busy_cnt, done_cnt, done_c, rd_cnt, clr_cnt;
    logic [31:0] a1_t [16];
    logic [15:0] em11, ea11;

    function automatic obs_t observe();
        obs_t o;
        o.ctl.busy = bif.busy;
        o.ctl.done = bif.done;
        o.ctl.own  = bif.ram_own;
        o.ctl.ar   = bif.ram_a_rden;
        o.ctl.wr   = bif.ram_w_rden;
        o.ctl.aa   = bif.ram_a_addr;
        o.ctl.wa   = bif.ram_w_addr;
        o.ctl.em   = bif.en_mult;
        o.ctl.ea   = bif.en_accum;
        o.ctl.cm   = bif.clr_mult;
        o.ctl.ca   = bif.clr_accum;
        o.ai       = bif.a_in;
        o.wi       = bif.w_in;
        return o;
    endfunction

    // Expected outputs in cycle c after start is sampled (c=1 is CLEAR).
    function automatic obs_t exp_rec(int k, int c);
        obs_t e;
        int   tt;
        int   tl;
        e  = '0;
        tl = k + 2 * (N - 1) + 3;
        if (c == 1) begin
            e.ctl.busy = 1'b1;
            e.ctl.own  = 1'b1;
            e.ctl.cm   = '1;
            e.ctl.ca   = '1;
        end else if (k == 0) begin
            if (c == 2) e.ctl.done = 1'b1;
        end else if (c >= 2 && c <= tl + 1) begin
            tt = c - 2;
            e.ctl.busy = 1'b1;
            e.ctl.own  = 1'b1;
            for (int i = 0; i < N; i++) begin
                if (tt >= i && tt < i + k) begin
                    e.ctl.ar[i] = 1'b1;
                    e.ctl.wr[i] = 1'b1;
                    e.ctl.aa[i] = 8'(tt - i);
                    e.ctl.wa[i] = 8'(tt - i);
                end
                if (tt >= 1 && tt - 1 >= i && tt - 1 < i + k) begin
                    e.ai[i] = amem[i][tt-1-i];
                    e.wi[i] = wmem[i][tt-1-i];
                end
                for (int j = 0; j < N; j++) begin
                    if (tt >= 1 + i + j && tt <= i + j + k) e.ctl.em[i][j] = 1'b1;
                    if (tt >= 2 + i + j && tt <= i + j + k + 1) e.ctl.ea[i][j] = 1'b1;
                end
            end
        end else if (c == tl + 2) begin
            e.ctl.done = 1'b1;
        end
        return e;
    endfunction

    task automatic run(input int k, input int restart_c, input int rst_c);
        obs_t q[$];
        obs_t o, e;
        int   c, nmax, tt;
        nmax = (k == 0) ? 3 : k + 2 * (N - 1) + 3 + 3;
        if (rst_c > 0) nmax = rst_c + 3;
        for (int i = 1; i <= nmax; i++)
            q.push_back((rst_c > 0 && i > rst_c) ? obs_t'('0) : exp_rec(k, i));
        busy_cnt = 0; done_cnt = 0; done_c = -1; rd_cnt = 0; clr_cnt = 0;
        em11 = '0; ea11 = '0;
        for (int i = 0; i < 16; i++) a1_t[i] = 32'hDEADBEEF;
        bif.start = 1'b1;
        bif.k_len = AW'(k);
        c = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            c++;
            o = observe();
            e = q.pop_front();
            n_chk++;
            if (o.ctl !== e.ctl)
                $display("FAIL ctl k=%0d c=%0d got=%h want=%h", k, c, o.ctl, e.ctl);
            else n_pass++;
            n_chk++;
            if ({o.ai, o.wi} !== {e.ai, e.wi})
                $display("FAIL data k=%0d c=%0d got=%h want=%h",
                         k, c, {o.ai, o.wi}, {e.ai, e.wi});
            else n_pass++;
            if (o.ctl.busy) busy_cnt++;
            if (o.ctl.done) begin done_cnt++; done_c = c; end
            if (o.ctl.ar != 0 || o.ctl.wr != 0) rd_cnt++;
            if (o.ctl.cm == '1) clr_cnt++;
            tt = c - 2;
            if (tt >= 0 && tt < 16) begin
                a1_t[tt] = o.ai[1];
                em11[tt] = o.ctl.em[1][1];
                ea11[tt] = o.ctl.ea[1][1];
            end
            bif.start = (restart_c > 0 && (c == restart_c || c == restart_c + 1));
            if (bif.start) bif.k_len = 8'd9;
            if (rst_c > 0 && c == rst_c) rst = 1'b1;
            if (rst_c > 0 && c == rst_c + 2) rst = 1'b0;
        end
        bif.start = 1'b0;
    endtask

    task automatic check_cout(input string tag);
        real want;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                want = 0.0;
                for (int kk = 0; kk < 4; kk++) want += a_r[i][kk] * w_r[j][kk];
                n_chk++;
                if (acc[i][j] != want)
                    $display("FAIL %s c_out[%0d][%0d] got=%f want=%f",
                             tag, i, j, acc[i][j], want);
                else n_pass++;
            end
    endtask

    task automatic test_reset();
        obs_t o;
        rst = 1'b1;
        bif.start = 1'b1;
        bif.k_len = 8'd4;
        repeat (3) begin
            @(negedge clk);
            o = observe();
            n_chk++;
            if (o !== '0) $display("FAIL reset_out got=%h want=0", o);
            else n_pass++;
        end
        rst = 1'b0;
        bif.start = 1'b0;
        @(negedge clk);
        o = observe();
        n_chk++;
        if (o !== '0) $display("FAIL reset_idle got=%h want=0", o);
        else n_pass++;
    endtask

    task automatic test_product();
        run(4, 0, 0);
        n_chk++;
        if (busy_cnt !== 10) $display("FAIL busy_len got=%0d want=10", busy_cnt);
        else n_pass++;
        n_chk++;
        if (done_c !== 11) $display("FAIL done_at got=%0d want=11", done_c);
        else n_pass++;
        n_chk++;
        if (done_cnt !== 1) $display("FAIL done_cnt got=%0d want=1", done_cnt);
        else n_pass++;
        check_cout("product");
    endtask

    task automatic test_skew();
        n_chk++;
        if (a1_t[1] !== 32'h0) $display("FAIL a_in1_t1 got=%h want=0", a1_t[1]);
        else n_pass++;
        n_chk++;
        if (a1_t[2] !== 32'h40A00000)
            $display("FAIL a_in1_t2 got=%h want=40a00000", a1_t[2]);
        else n_pass++;
        n_chk++;
        if (em11 !== 16'h0078) $display("FAIL en_mult11 got=%h want=0078", em11);
        else n_pass++;
        n_chk++;
        if (ea11 !== 16'h00F0) $display("FAIL en_accum11 got=%h want=00f0", ea11);
        else n_pass++;
    endtask

    task automatic test_k0();
        run(0, 0, 0);
        n_chk++;
        if (done_c !== 2) $display("FAIL k0_done_at got=%0d want=2", done_c);
        else n_pass++;
        n_chk++;
        if (rd_cnt !== 0) $display("FAIL k0_reads got=%0d want=0", rd_cnt);
        else n_pass++;
        n_chk++;
        if (clr_cnt !== 1) $display("FAIL k0_clears got=%0d want=1", clr_cnt);
        else n_pass++;
    endtask

    task automatic test_restart();
        run(4, 5, 0);
        n_chk++;
        if (done_cnt !== 1) $display("FAIL restart_done_cnt got=%0d want=1", done_cnt);
        else n_pass++;
        n_chk++;
        if (done_c !== 11) $display("FAIL restart_done_at got=%0d want=11", done_c);
        else n_pass++;
        check_cout("restart");
    endtask

    task automatic test_reset_mid();
        run(4, 0, 7);
        n_chk++;
        if (done_cnt !== 0) $display("FAIL abort_done got=%0d want=0", done_cnt);
        else n_pass++;
        n_chk++;
        if (busy_cnt !== 7) $display("FAIL abort_busy got=%0d want=7", busy_cnt);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        run(4, 0, 0);
        run(4, 0, 0);
        n_chk++;
        if (busy_cnt !== 10) $display("FAIL b2b_busy got=%0d want=10", busy_cnt);
        else n_pass++;
        n_chk++;
        if (done_c !== 11) $display("FAIL b2b_done_at got=%0d want=11", done_c);
        else n_pass++;
        check_cout("b2b");
    endtask

    initial begin
        logic [31:0] abits [N][4];
        logic [31:0] wbits [N][4];
        abits = '{'{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000},
                  '{32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000}};
        wbits = '{'{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000},
                  '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000}};
        a_r = '{'{1.0, 2.0, 3.0, 4.0}, '{5.0, 6.0, 7.0, 8.0}};
        w_r = '{'{1.0, 1.0, 1.0, 1.0}, '{0.5, 0.5, 0.5, 0.5}};
        for (int i = 0; i < N; i++)
            for (int a = 0; a < 256; a++) begin
                amem[i][a] = (a < 4) ? abits[i][a] : 32'h0;
                wmem[i][a] = (a < 4) ? wbits[i][a] : 32'h0;
            end
        rst = 1'b1;
        bif.start = 1'b0;
        bif.k_len = '0;
        test_reset();
        test_product();
        test_skew();
        test_k0();
        test_restart();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sys_arr_feeder.md
Name: sys_arr_feeder

Overview:
- Operand sequencer directly upstream of systolic_arr.
- On start, takes ownership of the four operand RAMs (W0/W1, A0/A1), reads K-deep rows of A and columns of W, and drives skewed a_in/w_in streams into the array.
- Generates per-PE en_mult/clr_mult/en_accum/clr_accum, then pulses done so the FSM can drain c_out over UART.
- Replaces FSM address control during compute via the ram_own select.

Parameters:
- N, 2, array dimension; number of A-row RAMs and W-column RAMs.
- ADDR_W, 8, RAM address width (256-deep RAM_32b_256).
- MULT_LAT, 1, fp multiplier latency inside a PE, in cycles.
- ACC_LAT, 1, fp accumulator latency inside a PE, in cycles.

Ports:
- clk  in  1  system clock (PLL c0).
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to run one matrix product.
- k_len  in  ADDR_W  inner dimension K; 0 = empty product.
- busy  out  1  high from the CLEAR state through the last RUN cycle.
- done  out  1  one-cycle pulse when all PE results are final.
- ram_own  out  1  high while busy; top level muxes RAM addr/rden to this block.
- ram_a_addr  out  N x ADDR_W  address to A RAM i.
- ram_a_rden  out  N  read enable to A RAM i.
- ram_a_q  in  N x 32  read data from A RAM i (1-cycle registered read).
- ram_w_addr  out  N x ADDR_W  address to W RAM j.
- ram_w_rden  out  N  read enable to W RAM j.
- ram_w_q  in  N x 32  read data from W RAM j.
- a_in  out  N x 32  row operand into systolic_arr a_in_raw[i].
- w_in  out  N x 32  column operand into systolic_arr w_in_raw[j].
- en_mult, clr_mult, en_accum, clr_accum  out  N x N each  per-PE controls.

Behaviour:
- Reset: state IDLE, counter t=0. All outputs 0: busy, done, ram_own, addr, rden, a_in, w_in, all enables and clears. Reset asserted mid-run aborts immediately; no done pulse.
- States: IDLE -> CLEAR -> RUN -> DONE -> IDLE.
- IDLE:
  - start=1 latches k_len into K and moves to CLEAR.
  - start while not in IDLE is ignored; K is frozen for the whole run.
- CLEAR (1 cycle):
  - busy=ram_own=1; clr_mult and clr_accum all ones.
  - If K=0, go to DONE; else go to RUN with t=0.
- RUN, counter t increments every cycle:
  - Row i: ram_a_rden[i]=1 and ram_a_addr[i]=t-i when i<=t<i+K, else rden=0 and addr=0.
  - Column j: same rule with t-j.
  - a_in[i] in cycle t+1 = ram_a_q[i] if row i read was issued in cycle t, else 32'h0. w_in[j] likewise. Zero-fill is mandatory so that bubbles are +0.0.
  - en_mult[i][j]=1 in cycles t = 1+i+j+k for k=0..K-1 (operand k reaches PE(i,j)).
  - en_accum[i][j] = en_mult[i][j] delayed MULT_LAT cycles.
  - RUN lasts T = K + 2(N-1) + 1 + MULT_LAT + ACC_LAT cycles (t = 0..T-1), then go to DONE.
  - The last accumulate for PE(N-1,N-1) completes at t=T-1.
- DONE (1 cycle): done=1; busy=ram_own=0; all enables 0; go to IDLE.
- K=0: no reads, no en_mult/en_accum; done is asserted 2 cycles after start is sampled.
- Counter width: ADDR_W+2 bits, sufficient for K=255.
- Address arithmetic never wraps: row i's address stays in [0, K-1].
- No back-pressure: once RUN starts it runs to completion.

Test Plan:
- Reset check: rst=1 for 3 cycles with start=1 -> all outputs 0, state stays IDLE.
- N=2, K=4, A0={1,2,3,4}, A1={5,6,7,8}, W0={1,1,1,1}, W1={0.5,0.5,0.5,0.5} (fp32):
  - busy high for 10 cycles.
  - done pulses exactly 11 cycles after start is sampled.
  - c_out = {{10,5},{26,13}}.
- Same run, skew check:
  - a_in[1] is 0 at RUN t=1, then 32'h40A00000 (5.0) at t=2.
  - en_mult[1][1] high exactly at t=3..6.
  - en_accum[1][1] high exactly at t=4..7.
- k_len=0 -> clears pulse once, no rden, done 2 cycles after start.
- start re-asserted at RUN t=3 -> ignored, single done.
- rst asserted at RUN t=5 -> next cycle all outputs 0 and no done.
- Back-to-back: start in the cycle after done -> second run identical to the first.
